// File: rtl/filter_trap.sv
// Trapezoidal / moving-sum shaping filter for unsigned ADC samples, with an optional peak capture stage.
// Define FILTER_TRAP_PEAK_EN to build the peak detector and the peak_missed counter.

module filter_trap #(
  parameter int DATA_W  = 12,
  parameter int LEN_MAX = 32,
  parameter int OUT_W   = DATA_W + $clog2(LEN_MAX) + 1,
  localparam int LW     = $clog2(LEN_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       input_data,
  input  logic                    mode,
  input  logic [LW-1:0]           rise_len,
  input  logic [LW-1:0]           gap_len,
  input  logic signed [OUT_W-1:0] threshold,
  output logic signed [OUT_W-1:0] output_data,
  output logic                    output_valid,
  output logic signed [OUT_W-1:0] peak_data,
  output logic                    peak_valid,
  input  logic                    peak_ready,
  output logic [7:0]              peak_missed
);

  localparam int DEPTH = 3 * LEN_MAX;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FILL, RUN} fill_state_t;

  // Configuration tracking
  logic          mode_q;
  logic [LW-1:0] rise_q;
  logic [LW-1:0] gap_q;
  logic          cfg_seen_q;
  logic          clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= 1'b0;
      rise_q     <= '0;
      gap_q      <= '0;
      cfg_seen_q <= 1'b0;
    end else begin
      mode_q     <= mode;
      rise_q     <= rise_len;
      gap_q      <= gap_len;
      cfg_seen_q <= 1'b1;
    end
  end

  // The first clk after reset always restarts, so a stale input register never leaks into acc.
  assign clear = !cfg_seen_q || (mode != mode_q) || (rise_len != rise_q) || (gap_len != gap_q);

  // Sample path: input register and delay line, no reset needed
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] dl [DEPTH];

  always_ff @(posedge clk) begin
    x_q   <= input_data;
    dl[0] <= x_q;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      dl[i] <= dl[i-1];
    end
  end

  // Effective window lengths
  logic [LW-1:0] k_eff;
  logic [LW-1:0] g_eff;
  logic [CW-1:0] k_c;
  logic [CW-1:0] l_c;
  logic [CW-1:0] kl_c;
  logic [CW-1:0] target;

  always_comb begin
    k_eff = (rise_q > LW'(LEN_MAX)) ? LW'(LEN_MAX) : rise_q;
    if (k_eff == '0) k_eff = LW'(1);
    g_eff  = (gap_q > LW'(LEN_MAX)) ? LW'(LEN_MAX) : gap_q;
    k_c    = CW'(k_eff);
    l_c    = k_c + CW'(g_eff);
    kl_c   = k_c + l_c;
    target = mode_q ? kl_c : k_c;
  end

  // Taps older than the samples accumulated since the last restart read as zero.
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [DATA_W-1:0]      tap_k;
  logic [DATA_W-1:0]      tap_l;
  logic [DATA_W-1:0]      tap_kl;
  logic signed [OUT_W-1:0] ext_n;
  logic signed [OUT_W-1:0] ext_k;
  logic signed [OUT_W-1:0] ext_l;
  logic signed [OUT_W-1:0] ext_kl;
  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] acc_next;
  logic signed [OUT_W-1:0] acc_d;

  always_comb begin
    tap_k  = (cnt_q >= k_c)  ? dl[AW'(k_c  - CW'(1))] : '0;
    tap_l  = (cnt_q >= l_c)  ? dl[AW'(l_c  - CW'(1))] : '0;
    tap_kl = (cnt_q >= kl_c) ? dl[AW'(kl_c - CW'(1))] : '0;
    ext_n  = OUT_W'(x_q);
    ext_k  = OUT_W'(tap_k);
    ext_l  = OUT_W'(tap_l);
    ext_kl = OUT_W'(tap_kl);
    if (mode_q) acc_next = acc_q + ext_n - ext_k - ext_l + ext_kl;
    else        acc_next = acc_q + ext_n - ext_k;
  end

  // Fill / run state machine
  fill_state_t state_q;
  fill_state_t state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_next;
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == target) state_d = RUN;
        end
        RUN:     ;
        default: state_d = FILL;
      endcase
    end
  end

  assign output_data  = acc_q;
  assign output_valid = (state_q == RUN);

`ifdef FILTER_TRAP_PEAK_EN
  typedef enum logic [1:0] {ARMED, TRACK, HOLD} peak_state_t;

  peak_state_t             pk_q;
  peak_state_t             pk_d;
  logic signed [OUT_W-1:0] max_q;
  logic signed [OUT_W-1:0] max_d;
  logic signed [OUT_W-1:0] pdata_q;
  logic signed [OUT_W-1:0] pdata_d;
  logic                    pvalid_q;
  logic                    pvalid_d;
  logic [7:0]              missed_q;
  logic [7:0]              missed_d;
  logic                    above_q;
  logic                    above_now;
  logic                    above_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pk_q     <= ARMED;
      max_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      missed_q <= '0;
      above_q  <= 1'b0;
    end else begin
      pk_q     <= pk_d;
      max_q    <= max_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      missed_q <= missed_d;
      above_q  <= above_d;
    end
  end

  always_comb begin
    pk_d      = pk_q;
    max_d     = max_q;
    pdata_d   = pdata_q;
    pvalid_d  = pvalid_q;
    missed_d  = missed_q;
    above_now = output_valid && (output_data > threshold);
    above_d   = clear ? 1'b0 : above_now;
    if (clear) begin
      pk_d     = ARMED;
      pvalid_d = 1'b0;
    end else begin
      case (pk_q)
        ARMED: begin
          if (above_now) begin
            pk_d  = TRACK;
            max_d = output_data;
          end
        end
        TRACK: begin
          if (output_valid) begin
            if (output_data >= max_q) begin
              max_d = output_data;
            end else begin
              pk_d     = HOLD;
              pdata_d  = max_q;
              pvalid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (peak_ready) begin
            pk_d     = ARMED;
            pvalid_d = 1'b0;
          end else if (above_now && !above_q && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
          end
        end
        default: pk_d = ARMED;
      endcase
    end
  end

  assign peak_data   = pdata_q;
  assign peak_valid  = pvalid_q;
  assign peak_missed = missed_q;
`else
  logic unused_peak;
  assign unused_peak = ^{peak_ready, threshold};
  assign peak_data   = '0;
  assign peak_valid  = 1'b0;
  assign peak_missed = '0;
`endif

endmodule
